// File: rtl/noc_pkg.sv
// Shared NoC definitions: default widths, header coordinate layout and the
// src/dst swap used when a packet is returned to its originator.
package noc_pkg;

  localparam int Noc_Data_Width = 32;
  localparam int Noc_Coord_W    = 2;

  // Header field offsets, in units of one coordinate field (multiply by C).
  localparam int Hdr_Dst_X_Field = 0;
  localparam int Hdr_Dst_Y_Field = 1;
  localparam int Hdr_Src_X_Field = 2;
  localparam int Hdr_Src_Y_Field = 3;

  // Widest flit the swap helper handles; callers zero-extend and truncate.
  localparam int Noc_Swap_Max = 128;
  typedef logic [Noc_Swap_Max-1:0] swap_word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_e;

  // Exchange the {dst_y,dst_x} pair with the {src_y,src_x} pair; payload untouched.
  function automatic swap_word_t hdr_swap(input swap_word_t flit, input int coord_w);
    swap_word_t pair_mask;
    swap_word_t dst_pair;
    swap_word_t src_pair;
    pair_mask = (swap_word_t'(1) << (Hdr_Src_X_Field * coord_w)) - swap_word_t'(1);
    dst_pair  = (flit >> (Hdr_Dst_X_Field * coord_w)) & pair_mask;
    src_pair  = (flit >> (Hdr_Src_X_Field * coord_w)) & pair_mask;
    return (flit & ~(pair_mask | (pair_mask << (Hdr_Src_X_Field * coord_w))))
         | (dst_pair << (Hdr_Src_X_Field * coord_w))
         | src_pair;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous FIFO with asynchronous-read head; status derived from the
// registered count so ready/valid never depend combinationally on the far side.
module noc_flit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/noc_empty_node.sv
// Terminator for an unused router local port: either swallows every flit or
// buffers whole packets and returns them with source and destination swapped.
module noc_empty_node
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = Noc_Data_Width,
  parameter int COORD_W    = Noc_Coord_W,
  parameter int MODE       = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail
);

  // Holds receive_ready low while reset is asserted and for the release edge.
  logic alive_q, alive_d;

  always_comb alive_d = 1'b1;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) alive_q <= 1'b0;
    else            alive_q <= alive_d;
  end

  generate
    if (MODE == 0) begin : g_sink
      logic unused_sink;
      assign unused_sink      = ^{receive_flit, receive_is_header, receive_is_tail,
                                  receive_valid, sender_ready};
      assign receive_ready    = alive_q;
      assign sender_valid     = 1'b0;
      assign sender_flit      = '0;
      assign sender_is_header = 1'b0;
      assign sender_is_tail   = 1'b0;
    end else begin : g_loop
      localparam int FW = DATA_WIDTH + 2;

      frame_state_e              state_q, state_d;
      logic                      accept, push, pop;
      logic                      full, empty;
      logic [FW-1:0]             head;
      logic [$clog2(FIFO_DEPTH):0] unused_count;
      logic [DATA_WIDTH-1:0]     head_flit, swapped_flit;
      logic                      head_hdr, head_tail;

      assign receive_ready = alive_q && !full;
      assign accept        = receive_valid && receive_ready;
      assign pop           = sender_ready && !empty;

      // Only flits belonging to a framed packet are queued; orphans are dropped.
      always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (accept) begin
          if (receive_is_header) begin
            push    = 1'b1;
            state_d = receive_is_tail ? IDLE : IN_PKT;
          end else if (state_q == IN_PKT) begin
            push = 1'b1;
            if (receive_is_tail) state_d = IDLE;
          end
        end
      end

      always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
      end

      noc_flit_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (noc_clk),
        .rst_n     (noc_rst_n),
        .push      (push),
        .push_data ({receive_is_header, receive_is_tail, receive_flit}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (unused_count)
      );

      assign head_flit    = head[DATA_WIDTH-1:0];
      assign head_tail    = head[DATA_WIDTH];
      assign head_hdr     = head[DATA_WIDTH+1];
      assign swapped_flit = DATA_WIDTH'(hdr_swap(swap_word_t'(head_flit), COORD_W));

      assign sender_valid     = !empty;
      assign sender_is_header = !empty && head_hdr;
      assign sender_is_tail   = !empty && head_tail;
      assign sender_flit      = empty    ? '0
                              : head_hdr ? swapped_flit
                              :            head_flit;
    end
  endgenerate

endmodule

// File: tb/tb_noc_empty_node.sv
// Directed bench for noc_empty_node: one loopback and one sink instance share
// stimulus; a queue model predicts every output on every falling edge.
module tb_noc_empty_node;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int DEPTH = 16;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b1;
  logic        receive_valid = 1'b0;
  logic [31:0] receive_flit = '0;
  logic        receive_is_header = 1'b0;
  logic        receive_is_tail = 1'b0;
  logic        sender_ready = 1'b0;

  logic        lb_receive_ready, lb_sender_valid, lb_sender_is_header, lb_sender_is_tail;
  logic [31:0] lb_sender_flit;
  logic        sk_receive_ready, sk_sender_valid, sk_sender_is_header, sk_sender_is_tail;
  logic [31:0] sk_sender_flit;

  int n_cmp = 0;
  int n_bad = 0;
  int lb_acc = 0;
  int sk_acc = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;

  typedef struct packed {
    logic        h;
    logic        t;
    logic [31:0] f;
  } ent_t;

  ent_t        mq[$];
  bit          m_in_pkt = 1'b0;
  bit          m_alive = 1'b0;
  logic        e_rdy, e_valid, e_h, e_t;
  logic [31:0] e_flit;

  noc_empty_node #(.MODE(1)) dut_lb (
    .noc_clk           (noc_clk),
    .noc_rst_n         (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (lb_receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .sender_valid      (lb_sender_valid),
    .sender_ready      (sender_ready),
    .sender_flit       (lb_sender_flit),
    .sender_is_header  (lb_sender_is_header),
    .sender_is_tail    (lb_sender_is_tail)
  );

  noc_empty_node #(.MODE(0)) dut_sk (
    .noc_clk           (noc_clk),
    .noc_rst_n         (noc_rst_n),
    .receive_valid     (receive_valid),
    .receive_ready     (sk_receive_ready),
    .receive_flit      (receive_flit),
    .receive_is_header (receive_is_header),
    .receive_is_tail   (receive_is_tail),
    .sender_valid      (sk_sender_valid),
    .sender_ready      (sender_ready),
    .sender_flit       (sk_sender_flit),
    .sender_is_header  (sk_sender_is_header),
    .sender_is_tail    (sk_sender_is_tail)
  );

  always #5 noc_clk = ~noc_clk;
  always @(posedge noc_clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endfunction

  // Return-to-sender: new dst = old src, new src = old dst, C = 2.
  function automatic logic [31:0] swap_model(input logic [31:0] f);
    logic [1:0] dx, dy, sx, sy;
    dx = f[1:0];
    dy = f[3:2];
    sx = f[5:4];
    sy = f[7:6];
    return {f[31:8], dy, dx, sy, sx};
  endfunction

  always @(negedge noc_clk) begin
    if (cmp_on) begin
      if (!noc_rst_n) begin
        mq.delete();
        m_in_pkt = 1'b0;
        m_alive  = 1'b0;
        e_rdy = 1'b0; e_valid = 1'b0; e_h = 1'b0; e_t = 1'b0; e_flit = '0;
      end else begin
        e_rdy   = m_alive && (mq.size() < DEPTH);
        e_valid = (mq.size() > 0);
        e_h     = e_valid ? mq[0].h : 1'b0;
        e_t     = e_valid ? mq[0].t : 1'b0;
        e_flit  = !e_valid ? 32'h0 : (mq[0].h ? swap_model(mq[0].f) : mq[0].f);
      end
      chk("lb_ready",  32'(lb_receive_ready),    32'(e_rdy));
      chk("lb_valid",  32'(lb_sender_valid),     32'(e_valid));
      chk("lb_flit",   lb_sender_flit,           e_flit);
      chk("lb_hdr",    32'(lb_sender_is_header), 32'(e_h));
      chk("lb_tail",   32'(lb_sender_is_tail),   32'(e_t));
      chk("sk_ready",  32'(sk_receive_ready),    32'(m_alive && noc_rst_n));
      chk("sk_valid",  32'(sk_sender_valid),     32'd0);
      chk("sk_flit",   sk_sender_flit,           32'd0);
      chk("sk_flags",  32'({sk_sender_is_header, sk_sender_is_tail}), 32'd0);
      if (noc_rst_n) begin
        if (e_valid && sender_ready) mq.delete(0);
        if (receive_valid && e_rdy) begin
          if (receive_is_header) begin
            mq.push_back({receive_is_header, receive_is_tail, receive_flit});
            m_in_pkt = !receive_is_tail;
          end else if (m_in_pkt) begin
            mq.push_back({receive_is_header, receive_is_tail, receive_flit});
            if (receive_is_tail) m_in_pkt = 1'b0;
          end
        end
        m_alive = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] f, input logic h, input logic t);
    bit got;
    got = 1'b0;
    receive_valid     = 1'b1;
    receive_flit      = f;
    receive_is_header = h;
    receive_is_tail   = t;
    for (int i = 0; i < 64; i++) begin
      @(negedge noc_clk);
      if (lb_receive_ready) begin
        got = 1'b1;
        lb_acc++;
        if (sk_receive_ready) sk_acc++;
        break;
      end
    end
    tick();
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL offer_timeout: actual not accepted required accepted flit %h", f);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge noc_clk);
      if (!lb_sender_valid) begin
        done = 1'b1;
        break;
      end
    end
    tick();
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_timeout: actual still valid required empty");
    end
  endtask

  logic [31:0] flits [20];
  logic        fh [20];
  logic        ft [20];
  int          start_cyc;

  initial begin
    #0.05 noc_rst_n = 1'b0;
    #0.1;
    chk("rst_lb_ready", 32'(lb_receive_ready), 32'd0);
    chk("rst_lb_valid", 32'(lb_sender_valid),  32'd0);
    chk("rst_sk_ready", 32'(sk_receive_ready), 32'd0);
    cmp_on = 1'b1;
    repeat (2) @(posedge noc_clk);
    #1;
    noc_rst_n    = 1'b1;
    sender_ready = 1'b1;
    tick();
    @(negedge noc_clk);
    chk("post_rst_lb_ready", 32'(lb_receive_ready), 32'd1);
    chk("post_rst_sk_ready", 32'(sk_receive_ready), 32'd1);
    tick();

    // Sink: four flits back to back.
    sk_acc = 0;
    start_cyc = cyc;
    offer(32'h1111_00E4, 1'b1, 1'b0);
    offer(32'h1111_0001, 1'b0, 1'b0);
    offer(32'h1111_0002, 1'b0, 1'b0);
    offer(32'h1111_0003, 1'b0, 1'b1);
    chk("sink_accepts", 32'(sk_acc), 32'd4);
    chk("sink_consecutive", 32'(cyc - start_cyc), 32'd4);
    drain();

    // Loopback single-flit packet.
    offer(32'h0000_00E4, 1'b1, 1'b1);
    @(negedge noc_clk);
    chk("single_flit", lb_sender_flit, 32'h0000_004E);
    chk("single_flags", 32'({lb_sender_is_header, lb_sender_is_tail}), 32'd3);
    tick();
    drain();

    // Backpressure: five 4-flit packets with the output stalled.
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 4; k++) begin
        flits[p*4+k] = (k == 0) ? (32'h0000_A0E4 + (p << 16)) : ((p << 16) | 32'h100 | k);
        fh[p*4+k]    = (k == 0);
        ft[p*4+k]    = (k == 3);
      end
    end
    sender_ready = 1'b0;
    lb_acc = 0;
    for (int i = 0; i < 16; i++) offer(flits[i], fh[i], ft[i]);
    receive_valid     = 1'b1;
    receive_flit      = flits[16];
    receive_is_header = fh[16];
    receive_is_tail   = ft[16];
    for (int i = 0; i < 3; i++) begin
      @(negedge noc_clk);
      chk("bp_ready_low", 32'(lb_receive_ready), 32'd0);
    end
    chk("bp_accepted", 32'(lb_acc), 32'd16);
    chk("bp_head", lb_sender_flit, 32'h0000_A04E);
    tick();
    sender_ready = 1'b1;
    for (int i = 16; i < 20; i++) offer(flits[i], fh[i], ft[i]);
    drain();

    // Orphan body flit in IDLE is dropped.
    offer(32'h0000_0BAD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge noc_clk);
      chk("orphan_drop", 32'(lb_sender_valid), 32'd0);
    end
    tick();

    // Truncated packet followed by a full one.
    offer(32'h0000_C0E4, 1'b1, 1'b0);
    offer(32'h0000_00C1, 1'b0, 1'b0);
    offer(32'h0000_D01B, 1'b1, 1'b0);
    offer(32'h0000_00D1, 1'b0, 1'b0);
    offer(32'h0000_00D2, 1'b0, 1'b1);
    drain();

    // Reset in the middle of a packet.
    sender_ready = 1'b0;
    offer(32'h0000_E0E4, 1'b1, 1'b0);
    offer(32'h0000_00E1, 1'b0, 1'b0);
    noc_rst_n = 1'b0;
    tick();
    tick();
    noc_rst_n = 1'b1;
    @(negedge noc_clk);
    chk("rstmid_empty", 32'(lb_sender_valid), 32'd0);
    tick();
    tick();
    sender_ready = 1'b1;
    offer(32'h0000_00E4, 1'b1, 1'b1);
    @(negedge noc_clk);
    chk("rstmid_loop", lb_sender_flit, 32'h0000_004E);
    tick();
    drain();

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
